// File: rtl/decode_hazard.sv
// decode_hazard: decode stage with register file, immediate extension,
// D/E pipeline register (flush > stall > capture) and load-use detection.
module decode_hazard #(
   parameter int XLEN    = 32,
   parameter int NREG    = 16,
   parameter int PC_REG  = 15,
   parameter int CW      = 10,
   parameter int MTR_BIT = 0,
   localparam int AW     = $clog2(NREG)
) (
   input  logic            Clk,
   input  logic            Rst,
   input  logic [31:0]     InstrD,
   input  logic [XLEN-1:0] PCPlus8D,
   input  logic [1:0]      RegSrcD,
   input  logic [1:0]      ImmSrcD,
   input  logic [CW-1:0]   CtrlD,
   input  logic            RegWriteW,
   input  logic [AW-1:0]   WA3W,
   input  logic [XLEN-1:0] ResultW,
   input  logic            StallD,
   input  logic            FlushE,
   output logic [XLEN-1:0] RD1E,
   output logic [XLEN-1:0] RD2E,
   output logic [XLEN-1:0] ExtImmE,
   output logic [AW-1:0]   WA3E,
   output logic [AW-1:0]   RA1E,
   output logic [AW-1:0]   RA2E,
   output logic [CW-1:0]   CtrlE,
   output logic [3:0]      CondE,
   output logic            ValidE,
   output logic            LoadUseD
);

   localparam logic [AW-1:0] PC_ADDR = AW'(PC_REG);

   logic [XLEN-1:0] regs_reg [NREG];
   logic [NREG-1:0] we;
   logic            wb_valid;
   logic [AW-1:0]   ra1_d, ra2_d, wa3_d;
   logic [XLEN-1:0] rd1_d, rd2_d, ext_imm_d;
   logic            hit1, hit2;
   logic            unused_instr;

   // Bits [27:24] carry opcode information decoded elsewhere into CtrlD.
   assign unused_instr = ^InstrD[27:24];

   assign ra1_d = RegSrcD[0] ? PC_ADDR : AW'(InstrD[19:16]);
   assign ra2_d = RegSrcD[1] ? AW'(InstrD[15:12]) : AW'(InstrD[3:0]);
   assign wa3_d = AW'(InstrD[15:12]);

   // The PC slot is never written; out-of-range addresses match no register.
   assign wb_valid = RegWriteW && (WA3W != PC_ADDR) && (32'(WA3W) < NREG);

   generate
      for (genvar gi = 0; gi < NREG; gi++) begin : g_we
         assign we[gi] = wb_valid && (WA3W == AW'(gi));
      end
   endgenerate

   // Register file: cleared by reset, one write port from writeback.
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         for (int i = 0; i < NREG; i++) regs_reg[i] <= '0;
      end else begin
         for (int i = 0; i < NREG; i++) begin
            if (we[i]) regs_reg[i] <= ResultW;
         end
      end
   end

   // Read ports: PC slot first, then same-cycle writeback bypass, then storage.
   always_comb begin
      rd1_d = '0;
      rd2_d = '0;
      if (ra1_d == PC_ADDR)                   rd1_d = PCPlus8D;
      else if (wb_valid && (WA3W == ra1_d))   rd1_d = ResultW;
      else if (32'(ra1_d) < NREG)             rd1_d = regs_reg[ra1_d];
      if (ra2_d == PC_ADDR)                   rd2_d = PCPlus8D;
      else if (wb_valid && (WA3W == ra2_d))   rd2_d = ResultW;
      else if (32'(ra2_d) < NREG)             rd2_d = regs_reg[ra2_d];
   end

   // Immediate extension by format.
   always_comb begin
      ext_imm_d = '0;
      case (ImmSrcD)
         2'b00:   ext_imm_d = {{(XLEN-8){1'b0}}, InstrD[7:0]};
         2'b01:   ext_imm_d = {{(XLEN-12){1'b0}}, InstrD[11:0]};
         2'b10:   ext_imm_d = {{(XLEN-26){InstrD[23]}}, InstrD[23:0], 2'b00};
         default: ext_imm_d = '0;
      endcase
   end

   // D/E register: flush beats stall, stall holds, otherwise capture.
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst || FlushE) begin
         RD1E    <= '0;
         RD2E    <= '0;
         ExtImmE <= '0;
         WA3E    <= '0;
         RA1E    <= '0;
         RA2E    <= '0;
         CtrlE   <= '0;
         CondE   <= '0;
         ValidE  <= 1'b0;
      end else if (!StallD) begin
         RD1E    <= rd1_d;
         RD2E    <= rd2_d;
         ExtImmE <= ext_imm_d;
         WA3E    <= wa3_d;
         RA1E    <= ra1_d;
         RA2E    <= ra2_d;
         CtrlE   <= CtrlD;
         CondE   <= InstrD[31:28];
         ValidE  <= 1'b1;
      end
   end

   // Load-use: a load in E whose destination feeds a source in D; the PC slot
   // is never produced by a load so it is excluded.
   assign hit1 = (WA3E == ra1_d) && (ra1_d != PC_ADDR);
   assign hit2 = (WA3E == ra2_d) && (ra2_d != PC_ADDR);
   assign LoadUseD = ValidE && CtrlE[MTR_BIT] && (hit1 || hit2);

endmodule

// File: tb/tb_decode_hazard.sv
// tb_decode_hazard: directed scenarios plus randomized traffic checked
// against a behavioural model of the decode stage.
module tb_decode_hazard;
   localparam int XLEN = 32;
   localparam int NREG = 16;
   localparam int AW   = 4;
   localparam int CW   = 10;
   localparam int PCR  = 15;

   logic            Clk = 1'b0;
   logic            Rst;
   logic [31:0]     InstrD;
   logic [XLEN-1:0] PCPlus8D;
   logic [1:0]      RegSrcD, ImmSrcD;
   logic [CW-1:0]   CtrlD;
   logic            RegWriteW;
   logic [AW-1:0]   WA3W;
   logic [XLEN-1:0] ResultW;
   logic            StallD, FlushE;
   logic [XLEN-1:0] RD1E, RD2E, ExtImmE;
   logic [AW-1:0]   WA3E, RA1E, RA2E;
   logic [CW-1:0]   CtrlE;
   logic [3:0]      CondE;
   logic            ValidE, LoadUseD;

   int n_cmp = 0;
   int n_bad = 0;

   // model state
   logic [XLEN-1:0] m_rf [NREG];
   logic [XLEN-1:0] e_rd1, e_rd2, e_imm;
   logic [AW-1:0]   e_wa3, e_ra1, e_ra2;
   logic [CW-1:0]   e_ctrl;
   logic [3:0]      e_cond;
   logic            e_valid;

   decode_hazard dut (
      .Clk(Clk), .Rst(Rst), .InstrD(InstrD), .PCPlus8D(PCPlus8D),
      .RegSrcD(RegSrcD), .ImmSrcD(ImmSrcD), .CtrlD(CtrlD),
      .RegWriteW(RegWriteW), .WA3W(WA3W), .ResultW(ResultW),
      .StallD(StallD), .FlushE(FlushE),
      .RD1E(RD1E), .RD2E(RD2E), .ExtImmE(ExtImmE),
      .WA3E(WA3E), .RA1E(RA1E), .RA2E(RA2E),
      .CtrlE(CtrlE), .CondE(CondE), .ValidE(ValidE), .LoadUseD(LoadUseD)
   );

   always #5 Clk = ~Clk;

   function automatic logic [AW-1:0] m_ra1();
      return RegSrcD[0] ? AW'(PCR) : InstrD[19:16];
   endfunction

   function automatic logic [AW-1:0] m_ra2();
      return RegSrcD[1] ? InstrD[15:12] : InstrD[3:0];
   endfunction

   function automatic logic [XLEN-1:0] m_read(logic [AW-1:0] a);
      if (a == AW'(PCR)) return PCPlus8D;
      if (RegWriteW && WA3W == a) return ResultW;
      return m_rf[a];
   endfunction

   function automatic logic [XLEN-1:0] m_imm(logic [31:0] ins, logic [1:0] s);
      case (s)
         2'd0:    return ins & 32'h0000_00FF;
         2'd1:    return ins & 32'h0000_0FFF;
         2'd2:    return 32'(int'({ins[23:0], 8'h00}) >>> 6);
         default: return 32'h0;
      endcase
   endfunction

   function automatic logic m_lu();
      logic [AW-1:0] a1, a2;
      a1 = m_ra1();
      a2 = m_ra2();
      return e_valid && e_ctrl[0] &&
             ((e_wa3 == a1 && a1 != AW'(PCR)) || (e_wa3 == a2 && a2 != AW'(PCR)));
   endfunction

   task automatic m_reset();
      for (int i = 0; i < NREG; i++) m_rf[i] = '0;
      e_rd1 = '0; e_rd2 = '0; e_imm = '0; e_wa3 = '0; e_ra1 = '0; e_ra2 = '0;
      e_ctrl = '0; e_cond = '0; e_valid = 1'b0;
   endtask

   // advance one clock, updating the model from the pre-edge inputs
   task automatic tick();
      logic [XLEN-1:0] n_rd1, n_rd2, n_imm;
      logic [AW-1:0]   n_wa3, n_ra1, n_ra2;
      logic [CW-1:0]   n_ctrl;
      logic [3:0]      n_cond;
      logic            n_valid, do_wr;
      n_rd1 = e_rd1; n_rd2 = e_rd2; n_imm = e_imm; n_wa3 = e_wa3;
      n_ra1 = e_ra1; n_ra2 = e_ra2; n_ctrl = e_ctrl; n_cond = e_cond; n_valid = e_valid;
      if (FlushE) begin
         n_rd1 = '0; n_rd2 = '0; n_imm = '0; n_wa3 = '0; n_ra1 = '0; n_ra2 = '0;
         n_ctrl = '0; n_cond = '0; n_valid = 1'b0;
      end else if (!StallD) begin
         n_ra1 = m_ra1(); n_ra2 = m_ra2();
         n_rd1 = m_read(n_ra1); n_rd2 = m_read(n_ra2);
         n_imm = m_imm(InstrD, ImmSrcD);
         n_wa3 = InstrD[15:12]; n_ctrl = CtrlD; n_cond = InstrD[31:28]; n_valid = 1'b1;
      end
      do_wr = RegWriteW && (WA3W != AW'(PCR));
      @(posedge Clk);
      #1;
      if (do_wr) m_rf[WA3W] = ResultW;
      e_rd1 = n_rd1; e_rd2 = n_rd2; e_imm = n_imm; e_wa3 = n_wa3; e_ra1 = n_ra1;
      e_ra2 = n_ra2; e_ctrl = n_ctrl; e_cond = n_cond; e_valid = n_valid;
   endtask

   task automatic drive_d(logic [31:0] ins, logic [1:0] rs, logic [1:0] is,
                          logic [CW-1:0] c, logic [XLEN-1:0] pc);
      InstrD = ins; RegSrcD = rs; ImmSrcD = is; CtrlD = c; PCPlus8D = pc;
   endtask

   task automatic drive_w(logic w, logic [AW-1:0] a, logic [XLEN-1:0] r);
      RegWriteW = w; WA3W = a; ResultW = r;
   endtask

   task automatic test_reset();
      Rst = 1'b1; StallD = 1'b0; FlushE = 1'b0;
      drive_d(32'hFFFF_FFFF, 2'b00, 2'b01, '1, 32'h44);
      drive_w(1'b1, 4'd2, 32'hFFFF_0000);
      repeat (2) @(posedge Clk);
      #1;
      n_cmp++; if (ValidE !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b expected 0", ValidE); end
      n_cmp++; if (CtrlE !== '0) begin n_bad++; $display("FAIL reset_ctrl: got %h expected 0", CtrlE); end
      n_cmp++; if ({RD1E, RD2E, ExtImmE} !== '0) begin n_bad++; $display("FAIL reset_data: got %h %h %h expected 0", RD1E, RD2E, ExtImmE); end
      n_cmp++; if ({WA3E, RA1E, RA2E, CondE} !== '0) begin n_bad++; $display("FAIL reset_addr: got %h expected 0", {WA3E, RA1E, RA2E, CondE}); end
      n_cmp++; if (LoadUseD !== 1'b0) begin n_bad++; $display("FAIL reset_loaduse: got %b expected 0", LoadUseD); end
      Rst = 1'b0;
      m_reset();
      // first edge after reset is a normal capture; R2 must still be 0
      drive_w(1'b0, 4'd0, 32'h0);
      drive_d(32'h7002_0000, 2'b00, 2'b00, 10'h0, 32'h8);
      tick();
      n_cmp++; if (ValidE !== 1'b1) begin n_bad++; $display("FAIL first_capture_valid: got %b expected 1", ValidE); end
      n_cmp++; if (RD1E !== 32'h0) begin n_bad++; $display("FAIL reset_beats_write: got %h expected 0", RD1E); end
      n_cmp++; if (CondE !== 4'h7) begin n_bad++; $display("FAIL first_capture_cond: got %h expected 7", CondE); end
      $display("test_reset done");
   endtask

   task automatic test_write_read();
      drive_w(1'b1, 4'd3, 32'h0000_00AA);
      drive_d(32'h0, 2'b00, 2'b00, 10'h0, 32'h8);
      tick();
      drive_w(1'b0, 4'd0, 32'h0);
      drive_d(32'h0003_0000, 2'b00, 2'b00, 10'h3, 32'hC);
      tick();
      n_cmp++; if (RD1E !== 32'h0000_00AA) begin n_bad++; $display("FAIL write_read_rd1: got %h expected 000000aa", RD1E); end
      n_cmp++; if (RA1E !== 4'd3) begin n_bad++; $display("FAIL write_read_ra1: got %h expected 3", RA1E); end
      $display("test_write_read done");
   endtask

   task automatic test_bypass();
      drive_w(1'b1, 4'd5, 32'h1234_5678);
      drive_d(32'h0000_0005, 2'b00, 2'b00, 10'h0, 32'h10);
      tick();
      drive_w(1'b0, 4'd0, 32'h0);
      n_cmp++; if (RD2E !== 32'h1234_5678) begin n_bad++; $display("FAIL bypass_rd2: got %h expected 12345678", RD2E); end
      n_cmp++; if (RA2E !== 4'd5) begin n_bad++; $display("FAIL bypass_ra2: got %h expected 5", RA2E); end
      $display("test_bypass done");
   endtask

   task automatic test_pc();
      drive_d(32'h0003_0000, 2'b01, 2'b00, 10'h0, 32'h0000_0108);
      tick();
      n_cmp++; if (RD1E !== 32'h0000_0108) begin n_bad++; $display("FAIL pc_rd1: got %h expected 00000108", RD1E); end
      n_cmp++; if (RA1E !== 4'hF) begin n_bad++; $display("FAIL pc_ra1: got %h expected f", RA1E); end
      // write to R15 in the same cycle as an R15 read: PC value wins
      drive_w(1'b1, 4'hF, 32'hDEAD_BEEF);
      drive_d(32'h0000_000F, 2'b00, 2'b00, 10'h0, 32'h0000_0200);
      tick();
      n_cmp++; if (RD2E !== 32'h0000_0200) begin n_bad++; $display("FAIL pc_no_bypass: got %h expected 00000200", RD2E); end
      drive_w(1'b0, 4'd0, 32'h0);
      drive_d(32'h0000_F000, 2'b10, 2'b00, 10'h0, 32'h0000_0300);
      tick();
      n_cmp++; if (RD2E !== 32'h0000_0300) begin n_bad++; $display("FAIL pc_after_write: got %h expected 00000300", RD2E); end
      $display("test_pc done");
   endtask

   task automatic test_imm();
      logic [31:0] ins [4] = '{32'h00FF_FFFE, 32'h0000_0080, 32'h0000_0ABC, 32'hFFFF_FFFF};
      logic [1:0]  src [4] = '{2'b10, 2'b00, 2'b01, 2'b11};
      logic [31:0] exp [4] = '{32'hFFFF_FFF8, 32'h0000_0080, 32'h0000_0ABC, 32'h0};
      for (int i = 0; i < 4; i++) begin
         drive_d(ins[i], 2'b00, src[i], 10'h0, 32'h8);
         tick();
         n_cmp++;
         if (ExtImmE !== exp[i]) begin
            n_bad++; $display("FAIL imm_case%0d: got %h expected %h", i, ExtImmE, exp[i]);
         end
      end
      $display("test_imm done");
   endtask

   task automatic test_stall_flush();
      // ra1=1 ra2=5 wa3=2 cond=E; R5 holds 12345678 from the bypass scenario
      drive_d(32'hE001_2005, 2'b00, 2'b00, 10'h155, 32'h8);
      tick();
      StallD = 1'b1;
      for (int i = 0; i < 2; i++) begin
         drive_d($urandom, 2'($urandom), 2'($urandom), 10'($urandom), $urandom);
         tick();
         n_cmp++;
         if ({CondE, WA3E, RA2E, CtrlE, ValidE} !== {4'hE, 4'd2, 4'd5, 10'h155, 1'b1}) begin
            n_bad++; $display("FAIL stall_hold%0d: got %h expected %h", i,
               {CondE, WA3E, RA2E, CtrlE, ValidE}, {4'hE, 4'd2, 4'd5, 10'h155, 1'b1});
         end
         n_cmp++; if (RD2E !== 32'h1234_5678) begin n_bad++; $display("FAIL stall_rd2_%0d: got %h expected 12345678", i, RD2E); end
      end
      FlushE = 1'b1;
      tick();
      FlushE = 1'b0; StallD = 1'b0;
      n_cmp++; if (ValidE !== 1'b0 || CtrlE !== '0) begin n_bad++; $display("FAIL flush_over_stall: got valid=%b ctrl=%h expected 0 0", ValidE, CtrlE); end
      n_cmp++; if (RD2E !== '0 || WA3E !== '0) begin n_bad++; $display("FAIL flush_data: got rd2=%h wa3=%h expected 0 0", RD2E, WA3E); end
      $display("test_stall_flush done");
   endtask

   task automatic test_load_use();
      drive_d(32'h0000_4000, 2'b00, 2'b00, 10'h001, 32'h8);   // load to R4
      tick();
      drive_d(32'h0004_0000, 2'b00, 2'b00, 10'h0, 32'h8);     // RA1=4
      #1;
      n_cmp++; if (LoadUseD !== 1'b1) begin n_bad++; $display("FAIL lu_ra1: got %b expected 1", LoadUseD); end
      drive_d(32'h0007_4000, 2'b10, 2'b00, 10'h0, 32'h8);     // RA2=Instr[15:12]=4
      #1;
      n_cmp++; if (LoadUseD !== 1'b1) begin n_bad++; $display("FAIL lu_ra2: got %b expected 1", LoadUseD); end
      drive_d(32'h0007_0003, 2'b00, 2'b00, 10'h0, 32'h8);     // no match
      #1;
      n_cmp++; if (LoadUseD !== 1'b0) begin n_bad++; $display("FAIL lu_nomatch: got %b expected 0", LoadUseD); end
      drive_d(32'h0000_F000, 2'b00, 2'b00, 10'h001, 32'h8);   // "load" to R15
      tick();
      drive_d(32'h0000_000F, 2'b01, 2'b00, 10'h0, 32'h8);     // both sources R15
      #1;
      n_cmp++; if (LoadUseD !== 1'b0) begin n_bad++; $display("FAIL lu_pc_excluded: got %b expected 0", LoadUseD); end
      drive_d(32'h0000_4000, 2'b00, 2'b00, 10'h3FE, 32'h8);   // non-load to R4
      tick();
      drive_d(32'h0004_0000, 2'b00, 2'b00, 10'h0, 32'h8);
      #1;
      n_cmp++; if (LoadUseD !== 1'b0) begin n_bad++; $display("FAIL lu_not_load: got %b expected 0", LoadUseD); end
      drive_d(32'h0000_4000, 2'b00, 2'b00, 10'h001, 32'h8);
      tick();
      drive_d(32'h0004_0000, 2'b00, 2'b00, 10'h0, 32'h8);
      FlushE = 1'b1;
      tick();
      FlushE = 1'b0;
      n_cmp++; if (LoadUseD !== 1'b0) begin n_bad++; $display("FAIL lu_after_flush: got %b expected 0", LoadUseD); end
      $display("test_load_use done");
   endtask

   task automatic test_async_reset();
      drive_w(1'b1, 4'd6, 32'h0000_0055);
      drive_d(32'h9006_0000, 2'b00, 2'b00, 10'h2AA, 32'h8);
      tick();
      drive_w(1'b0, 4'd0, 32'h0);
      StallD = 1'b1;
      tick();
      tick();
      n_cmp++; if (RD1E !== 32'h55 || ValidE !== 1'b1) begin n_bad++; $display("FAIL pre_reset_hold: got rd1=%h valid=%b expected 55 1", RD1E, ValidE); end
      #2 Rst = 1'b1;
      #1;
      n_cmp++; if ({RD1E, CtrlE, CondE, ValidE} !== '0) begin n_bad++; $display("FAIL async_reset: got %h expected 0", {RD1E, CtrlE, CondE, ValidE}); end
      #1 Rst = 1'b0;
      m_reset();
      #1;
      n_cmp++; if (ValidE !== 1'b0) begin n_bad++; $display("FAIL reset_release_empty: got %b expected 0", ValidE); end
      StallD = 1'b0;
      tick();
      n_cmp++; if (ValidE !== 1'b1 || RD1E !== 32'h0) begin n_bad++; $display("FAIL post_reset_capture: got valid=%b rd1=%h expected 1 0", ValidE, RD1E); end
      $display("test_async_reset done");
   endtask

   task automatic test_random();
      int bad0;
      bad0 = n_bad;
      for (int c = 0; c < 300; c++) begin
         drive_d($urandom, 2'($urandom), 2'($urandom), 10'($urandom), $urandom);
         if ($urandom_range(0, 2) == 0) InstrD[19:16] = e_wa3;
         drive_w(1'($urandom), 4'($urandom), $urandom);
         StallD = ($urandom_range(0, 3) == 0);
         FlushE = ($urandom_range(0, 9) == 0);
         #1;
         n_cmp++; if (LoadUseD !== m_lu()) begin n_bad++; $display("FAIL rnd_loaduse c%0d: got %b expected %b", c, LoadUseD, m_lu()); end
         tick();
         n_cmp++; if (RD1E !== e_rd1) begin n_bad++; $display("FAIL rnd_rd1 c%0d: got %h expected %h", c, RD1E, e_rd1); end
         n_cmp++; if (RD2E !== e_rd2) begin n_bad++; $display("FAIL rnd_rd2 c%0d: got %h expected %h", c, RD2E, e_rd2); end
         n_cmp++; if (ExtImmE !== e_imm) begin n_bad++; $display("FAIL rnd_imm c%0d: got %h expected %h", c, ExtImmE, e_imm); end
         n_cmp++; if ({WA3E, RA1E, RA2E} !== {e_wa3, e_ra1, e_ra2}) begin n_bad++; $display("FAIL rnd_addr c%0d: got %h expected %h", c, {WA3E, RA1E, RA2E}, {e_wa3, e_ra1, e_ra2}); end
         n_cmp++; if ({CtrlE, CondE, ValidE} !== {e_ctrl, e_cond, e_valid}) begin n_bad++; $display("FAIL rnd_ctrl c%0d: got %h expected %h", c, {CtrlE, CondE, ValidE}, {e_ctrl, e_cond, e_valid}); end
      end
      StallD = 1'b0; FlushE = 1'b0; RegWriteW = 1'b0;
      $display("test_random done, %0d new mismatches", n_bad - bad0);
   endtask

   initial begin
      m_reset();
      test_reset();
      test_write_read();
      test_bypass();
      test_pc();
      test_imm();
      test_stall_flush();
      test_load_use();
      test_async_reset();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end
endmodule

// File: doc/decode_hazard.md
DECODE_HAZARD -- requirements
Module: decode_hazard

Interface
REQ-001 Parameter XLEN, default 32, datapath and register width.
REQ-002 Parameter NREG, default 16, register count; AW = clog2(NREG) address bits.
REQ-003 Parameter PC_REG, default 15, register index that reads as PCPlus8D.
REQ-004 Parameter CW, default 10, control-bundle width.
REQ-005 Parameter MTR_BIT, default 0, index of the MemToReg bit within the control bundle.
REQ-006 The block SHALL have one clock and an asynchronous, active-high reset, with ports as follows:
- Clk  in  1  clock, all state on the rising edge.
- Rst  in  1  asynchronous active-high reset.
- InstrD  in  32  instruction in decode.
- PCPlus8D  in  XLEN  PC+8 of the decode instruction.
- RegSrcD  in  2  bit0 selects RA1 = PC_REG; bit1 selects RA2 = Instr[15:12], otherwise Instr[3:0].
- ImmSrcD  in  2  immediate format.
- CtrlD  in  CW  decoded control bundle.
- RegWriteW  in  1  writeback enable.
- WA3W  in  AW  writeback address.
- ResultW  in  XLEN  writeback data.
- StallD  in  1  hold the D/E register.
- FlushE  in  1  insert a bubble in E.
- RD1E, RD2E  out  XLEN  registered operands.
- ExtImmE  out  XLEN  registered immediate.
- WA3E, RA1E, RA2E  out  AW  registered destination and source addresses.
- CtrlE  out  CW  registered control bundle.
- CondE  out  4  registered Instr[31:28].
- ValidE  out  1  E slot holds a real instruction.
- LoadUseD  out  1  combinational load-use hazard request.

Function
REQ-007 RA1D SHALL be Instr[19:16], or PC_REG when RegSrcD[0]=1; RA2D SHALL be Instr[3:0], or Instr[15:12] when RegSrcD[1]=1; WA3D SHALL be Instr[15:12].
REQ-008 The register file SHALL hold NREG words of XLEN bits.
REQ-009 On a rising Clk with RegWriteW=1 and WA3W != PC_REG, the register file SHALL write ResultW to WA3W.
REQ-010 A write to PC_REG SHALL be ignored.
REQ-011 Register-file writes SHALL occur regardless of StallD and FlushE.
REQ-012 Each read port SHALL return PCPlus8D when its address = PC_REG.
REQ-013 Otherwise, a read port SHALL return ResultW when RegWriteW=1 and WA3W equals its address (write-through bypass, same cycle).
REQ-014 Otherwise, a read port SHALL return the stored word.
REQ-015 The immediate SHALL be extended as follows:
- ImmSrcD 00: zero-extend Instr[7:0].
- ImmSrcD 01: zero-extend Instr[11:0].
- ImmSrcD 10: sign-extend {Instr[23:0], 2'b00} to XLEN.
- ImmSrcD 11: all-zero.
REQ-016 The D/E register SHALL implement a 3-way priority on each rising Clk (FlushE, then StallD, then normal) with the following behaviour:
- FlushE=1: CtrlE=0, ValidE=0, all data and address fields 0; FlushE wins over StallD.
- Else StallD=1: all E outputs hold their value.
- Else: capture RD1, RD2, immediate, WA3D, RA1D, RA2D, CtrlD, Instr[31:28]; ValidE=1.
REQ-017 Latency from decode inputs to E outputs SHALL be exactly 1 cycle when not stalled.
REQ-018 LoadUseD SHALL be ValidE & CtrlE[MTR_BIT] & ((WA3E==RA1D) | (WA3E==RA2D)), excluding any match whose address equals PC_REG.
REQ-019 LoadUseD SHALL be purely combinational; the block SHALL NOT self-stall, and the external hazard unit drives StallD and FlushE.
REQ-020 Address arithmetic SHALL be unsigned AW bits with no wrap; WA3W values >= NREG SHALL be ignored.

Reset
REQ-021 Rst=1 SHALL asynchronously clear all NREG registers to 0.
REQ-022 Rst=1 SHALL asynchronously clear all E outputs to 0, including ValidE=0 and CtrlE=0.
REQ-023 Rst SHALL take precedence over StallD, FlushE and RegWriteW.
REQ-024 Reset asserted mid-stall SHALL leave the block empty after release.
REQ-025 The first rising Clk after Rst deasserts SHALL behave as normal capture.

Verification
REQ-026 Write then read: write R3=0x0000_00AA in cycle n; read R3 in cycle n+1 -> RD1E=0x0000_00AA at n+2.
REQ-027 Bypass: RegWriteW=1, WA3W=5, ResultW=0x1234_5678 with RA2D=5 in the same cycle -> RD2E=0x1234_5678 next cycle.
REQ-028 PC read: RegSrcD[0]=1, PCPlus8D=0x0000_0108 -> RD1E=0x0000_0108; a write to R15 of 0xDEAD_BEEF is ignored, and a later R15 read returns the current PCPlus8D.
REQ-029 Immediate: ImmSrcD=10, Instr[23:0]=0xFFFFFE -> ExtImmE=0xFFFF_FFF8; ImmSrcD=00, Instr[7:0]=0x80 -> ExtImmE=0x0000_0080.
REQ-030 Stall/flush: StallD=1 for 2 cycles -> E outputs constant; StallD=1 and FlushE=1 together -> ValidE=0, CtrlE=0.
REQ-031 Load-use: ValidE=1, CtrlE[MTR_BIT]=1, WA3E=4, RA1D=4 -> LoadUseD=1; after FlushE -> LoadUseD=0.
REQ-032 Async reset: assert Rst between clock edges during a stall -> outputs go to 0 immediately, with no clock edge needed.
